// File: rtl/frame_stream_arbiter_pkg.sv
// Shared video-path definitions: arbiter state encoding, frame geometry and
// the channel-index width helper used by frame_stream_arbiter and rr_picker.
package frame_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        PASS = 2'd2
    } state_t;

    localparam int FRAME_W   = 640;
    localparam int FRAME_H   = 480;
    localparam int FRAME_PIX = FRAME_W * FRAME_H;

    // Index width for n channels; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_stream_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req searching upward
// from (last+1) mod N with wrap-around.
module frame_stream_arbiter_rr_picker
    import frame_stream_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                found = 1'b1;
                index = IDX_W'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/frame_stream_arbiter.sv
// Frame-granular round-robin arbiter feeding one AXI-Stream pixel filter.
// Optional FRAME_LEN_CHECK_EN: force tlast at FRAME_PIX beats, sticky err_len.
module frame_stream_arbiter
    import frame_stream_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int FRAME_PIX = frame_stream_arbiter_pkg::FRAME_PIX,
    parameter int CNT_W     = 19
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH*DATA_W-1:0]     s_tdata,
    input  logic [NUM_CH-1:0]            s_tkeep,
    input  logic [NUM_CH-1:0]            s_tlast,
    input  logic [NUM_CH-1:0]            s_tvalid,
    output logic [NUM_CH-1:0]            s_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic                         m_tkeep,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [idx_width(NUM_CH)-1:0] m_tid,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_len
);

    localparam int ID_W = idx_width(NUM_CH);

    state_t            state_reg;
    logic [ID_W-1:0]   grant_reg;
    logic [ID_W-1:0]   last_grant_reg;
    logic [ID_W-1:0]   tid_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic              frame_done_reg;

    logic              found;
    logic [ID_W-1:0]   pick;
    logic              in_pass;
    logic              hs;
    logic              len_hit;

    frame_stream_arbiter_rr_picker #(
        .N     (NUM_CH),
        .IDX_W (ID_W)
    ) u_picker (
        .req   (s_tvalid),
        .last  (last_grant_reg),
        .found (found),
        .index (pick)
    );

    assign in_pass = (state_reg == PASS);
    assign len_hit = (cnt_reg == CNT_W'(FRAME_PIX - 1));

    // Zero-latency pass-through of the granted source; everything idles low otherwise.
    always_comb begin
        m_tvalid = 1'b0;
        m_tkeep  = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = '0;
        if (in_pass) begin
            m_tvalid = s_tvalid[grant_reg];
            m_tkeep  = s_tkeep[grant_reg];
            m_tdata  = s_tdata[int'(grant_reg)*DATA_W +: DATA_W];
`ifdef FRAME_LEN_CHECK_EN
            m_tlast  = s_tlast[grant_reg] | len_hit;
`else
            m_tlast  = s_tlast[grant_reg];
`endif
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
        assign s_tready[gi] = in_pass && (grant_reg == ID_W'(gi)) && m_tready;
    end

    assign hs = m_tvalid && m_tready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= ID_W'(NUM_CH - 1);
            tid_reg        <= '0;
            cnt_reg        <= '0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: state_reg <= ARB;
                ARB: begin
                    if (found) begin
                        grant_reg <= pick;
                        tid_reg   <= pick;
                        busy_reg  <= 1'b1;
                        state_reg <= PASS;
                    end
                end
                PASS: begin
                    if (hs) begin
                        if (m_tlast) begin
                            cnt_reg        <= '0;
                            last_grant_reg <= grant_reg;
                            frame_done_reg <= 1'b1;
                            busy_reg       <= 1'b0;
                            state_reg      <= ARB;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_LEN_CHECK_EN
    logic err_len_reg;

    // A frame is malformed if tlast comes early, or if the length limit had to cut it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_len_reg <= 1'b0;
        end else if (hs && (s_tlast[grant_reg] ? !len_hit : len_hit)) begin
            err_len_reg <= 1'b1;
        end
    end

    assign err_len = err_len_reg;
`else
    logic unused_len_hit;
    assign unused_len_hit = len_hit;
    assign err_len        = 1'b0;
`endif

    assign m_tid      = tid_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Directed bench for frame_stream_arbiter: per-channel source queues drive the
// inputs, an expected-beat scoreboard is checked whenever the filter accepts a beat.
module tb_frame_stream_arbiter;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 8;
    localparam int FRAME_PIX = 16;
    localparam int CNT_W     = 5;
`ifdef FRAME_LEN_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [NUM_CH*DATA_W-1:0] s_tdata = '0;
    logic [NUM_CH-1:0]        s_tkeep = '0;
    logic [NUM_CH-1:0]        s_tlast = '0;
    logic [NUM_CH-1:0]        s_tvalid = '0;
    logic [NUM_CH-1:0]        s_tready;
    logic [DATA_W-1:0]        m_tdata;
    logic                     m_tkeep;
    logic                     m_tlast;
    logic                     m_tvalid;
    logic                     m_tready = 1'b0;
    logic [1:0]               m_tid;
    logic                     busy;
    logic                     frame_done;
    logic                     err_len;

    frame_stream_arbiter #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .FRAME_PIX (FRAME_PIX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tid      (m_tid),
        .busy       (busy),
        .frame_done (frame_done),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int beat_cnt = 0;
    int fd_cnt   = 0;

    logic [8:0]        src_q [NUM_CH][$];   // {last, data}
    logic [10:0]       exp_q [$];           // {tid, data, last}
    logic [NUM_CH-1:0] src_en    = '1;
    logic              tog_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sources();
        logic [8:0] e;
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                e = src_q[i][0];
                s_tvalid[i] = 1'b1;
                s_tkeep[i]  = 1'b1;
                s_tlast[i]  = e[8];
                s_tdata[i*DATA_W +: DATA_W] = e[7:0];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tkeep[i]  = 1'b0;
                s_tlast[i]  = 1'b0;
                s_tdata[i*DATA_W +: DATA_W] = '0;
            end
        end
    endtask

    // One clock: sample acceptances before the edge, advance sources just after it.
    task automatic tick();
        logic [NUM_CH-1:0] acc;
        @(negedge clk);
        acc = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++)
            if (acc[i] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (tog_ready) m_tready = ~m_tready;
        drive_sources();
    endtask

    function automatic logic [7:0] pix(input int ch, input int k);
        return {3'(ch), 5'(k)};
    endfunction

    task automatic src_frame(input int ch, input int n, input int last_at, input int base);
        for (int k = 0; k < n; k++) src_q[ch].push_back({(k + 1 == last_at), pix(ch, base + k)});
    endtask

    task automatic exp_frame(input int ch, input int n, input int last_at, input int base);
        for (int k = 0; k < n; k++) exp_q.push_back({2'(ch), pix(ch, base + k), (k + 1 == last_at)});
    endtask

    task automatic run_until_empty(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int i = 0; i < NUM_CH; i++) src_q[i].delete();
        exp_q.delete();
        drive_sources();
        tick();
        tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_m_tdata"}, m_tdata, 0);
        chk({tag, "_m_tlast"}, m_tlast, 0);
        chk({tag, "_m_tkeep"}, m_tkeep, 0);
        chk({tag, "_m_tid"}, m_tid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_err_len"}, err_len, 0);
    endtask

    // Scoreboard and per-cycle ready checks.
    always @(negedge clk) begin
        logic [10:0] e;
        if (rstn) begin
            if (frame_done) fd_cnt++;
            if (busy) begin
                chk("nongranted_ready", s_tready & ~(4'b0001 << m_tid), 0);
            end else begin
                chk("idle_s_tready", s_tready, 0);
                chk("idle_m_tvalid", m_tvalid, 0);
            end
            if (m_tvalid && m_tready) begin
                beat_cnt++;
                $display("beat tid=%0d data=0x%02h last=%0b", m_tid, m_tdata, m_tlast);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_queue", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_tid, m_tdata, m_tlast}, e);
                end
            end
        end
    end

    initial begin
        int fd0;
        int b0;
        int n;

        // Reset values, then a single 16-beat frame on channel 2.
        do_reset();
        chk_reset_values("reset");
        src_frame(2, 16, 16, 0);
        exp_frame(2, 16, 16, 0);
        m_tready = 1'b1;
        drive_sources();
        fd0  = fd_cnt;
        rstn = 1'b1;
        tick();
        chk("t1_idle_busy", busy, 0);
        tick();
        chk("t1_arb_busy", busy, 1);
        chk("t1_tid", m_tid, 2);
        chk("t1_first_valid", m_tvalid, 1);
        run_until_empty("t1", 100);
        chk("t1_frame_done", frame_done, 1);
        chk("t1_back_to_arb", busy, 0);
        tick();
        chk("t1_frame_done_clear", frame_done, 0);
        tick();
        chk("t1_fd_count", fd_cnt - fd0, 1);

        // All four channels valid, 3-beat frames, round-robin order from channel 0.
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int ch = 0; ch < NUM_CH; ch++) begin
                src_frame(ch, 3, 3, f * 16);
                exp_frame(ch, 3, 3, f * 16);
            end
        drive_sources();
        rstn = 1'b1;
        run_until_empty("t2", 200);

        // Channel 1 with toggling m_tready and a 5-cycle valid drop mid-frame.
        src_frame(1, 16, 16, 0);
        exp_frame(1, 16, 16, 0);
        tog_ready = 1'b1;
        b0 = beat_cnt;
        drive_sources();
        repeat (8) tick();
        src_en[1] = 1'b0;
        drive_sources();
        repeat (5) tick();
        chk("t3_grant_held", m_tid, 1);
        chk("t3_busy_held", busy, 1);
        src_en[1] = 1'b1;
        drive_sources();
        run_until_empty("t3", 200);
        chk("t3_total_beats", beat_cnt - b0, 16);
        tog_ready = 1'b0;
        m_tready  = 1'b1;

        // Reset after beat 7 of a channel-3 frame.
        src_frame(3, 16, 16, 0);
        exp_frame(3, 16, 16, 0);
        drive_sources();
        b0 = beat_cnt;
        n  = 0;
        while (beat_cnt - b0 < 7 && n < 100) begin
            tick();
            n++;
        end
        chk("t4_reached_beat7", beat_cnt - b0, 7);
        rstn = 1'b0;
        tick();
        chk_reset_values("t4_mid_reset");
        do_reset();
        src_frame(0, 4, 4, 0);
        src_frame(1, 4, 4, 0);
        src_frame(3, 4, 4, 0);
        exp_frame(0, 4, 4, 0);
        exp_frame(1, 4, 4, 0);
        exp_frame(3, 4, 4, 0);
        drive_sources();
        rstn = 1'b1;
        tick();
        tick();
        chk("t4_first_grant", m_tid, 0);
        run_until_empty("t4", 100);

`ifdef FRAME_LEN_CHECK_EN
        // 20 beats without tlast: cut at 16, remainder becomes the next frame.
        do_reset();
        src_frame(2, 20, 0, 0);
        exp_frame(2, 16, 16, 0);
        exp_frame(2, 4, 0, 16);
        drive_sources();
        fd0  = fd_cnt;
        rstn = 1'b1;
        run_until_empty("t5", 200);
        chk("t5_err_len", err_len, 1);
        chk("t5_open_frame", busy, 1);
        repeat (3) tick();
        chk("t5_err_sticky", err_len, 1);
        chk("t5_fd_count", fd_cnt - fd0, 1);
`endif

        // Early tlast on beat 10.
        do_reset();
        chk("t6_err_after_reset", err_len, 0);
        src_frame(1, 10, 10, 0);
        exp_frame(1, 10, 10, 0);
        drive_sources();
        fd0  = fd_cnt;
        rstn = 1'b1;
        run_until_empty("t6", 100);
        tick();
        chk("t6_err_len", err_len, ERR_EXP);
        chk("t6_fd_count", fd_cnt - fd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
